// File: rtl/avmm_cfg_pkg.sv
// Shared constants and types for the Avalon-MM configuration bus.
// Imported by the responder and by the initiator-side sequencers.
package avmm_cfg_pkg;

    localparam int CFG_ADDR_W = 17;
    localparam int CFG_DATA_W = 32;
    localparam int CFG_BE_W   = 4;

    localparam logic [10:0] CFG_OFS_R0 = 11'h208;
    localparam logic [10:0] CFG_OFS_R1 = 11'h210;
    localparam logic [10:0] CFG_OFS_R2 = 11'h218;

    // Select code for offsets outside the register bank
    localparam logic [1:0] CFG_SEL_NONE = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACK     = 2'd1,
        RD_DATA = 2'd2
    } cfg_resp_state_e;

    function automatic logic [1:0] cfg_ofs_sel(input logic [10:0] ofs);
        case (ofs)
            CFG_OFS_R0: return 2'd0;
            CFG_OFS_R1: return 2'd1;
            CFG_OFS_R2: return 2'd2;
            default:    return CFG_SEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/avmm_cfg_ch_regs.sv
// One channel's bank: three byte-enabled config registers with
// written-tracking and a registered "all three written" flag.
module avmm_cfg_ch_regs
    import avmm_cfg_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  wr_en,
    input  logic [1:0]            wr_sel,
    input  logic [CFG_DATA_W-1:0] wr_data,
    input  logic [CFG_BE_W-1:0]   wr_be,
    input  logic [1:0]            rd_sel,
    output logic [CFG_DATA_W-1:0] rd_data,
    output logic                  done
);

    logic [CFG_DATA_W-1:0] regs [3];
    logic [2:0]            written;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs    <= '{default: '0};
            written <= '0;
            done    <= 1'b0;
        end else begin
            for (int unsigned r = 0; r < 3; r++) begin
                if (wr_en && wr_sel == 2'(r)) begin
                    for (int unsigned b = 0; b < CFG_BE_W; b++) begin
                        if (wr_be[b])
                            regs[r][8*b +: 8] <= wr_data[8*b +: 8];
                    end
                end
                // A commit coinciding with clear wins for its own flag
                if (wr_en && wr_sel == 2'(r))
                    written[r] <= 1'b1;
                else if (clear)
                    written[r] <= 1'b0;
            end
            done <= clear ? 1'b0 : &written;
        end
    end

    always_comb begin
        rd_data = '0;
        case (rd_sel)
            2'd0:    rd_data = regs[0];
            2'd1:    rd_data = regs[1];
            2'd2:    rd_data = regs[2];
            default: rd_data = '0;
        endcase
    end

endmodule

// File: rtl/avmm_cfg_responder.sv
// Avalon-MM config responder: waitrequest handshake, fixed read latency,
// per-channel register banks, completion tracking and error counting.
module avmm_cfg_responder
    import avmm_cfg_pkg::*;
#(
    parameter int                    NUM_CH         = 24,
    parameter logic [CFG_DATA_W-1:0] UNMAPPED_RDATA = 32'hDEAD_BEEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CFG_ADDR_W-1:0] avs_address,
    input  logic                  avs_write,
    input  logic                  avs_read,
    input  logic [CFG_DATA_W-1:0] avs_writedata,
    input  logic [CFG_BE_W-1:0]   avs_byteenable,
    output logic                  avs_waitrequest,
    output logic [CFG_DATA_W-1:0] avs_readdata,
    output logic                  avs_readdatavalid,
    input  logic                  cfg_clear,
    output logic [NUM_CH-1:0]     cfg_done,
    output logic [7:0]            err_cnt
);

    localparam logic [5:0] NUM_CH_L = 6'(NUM_CH);

    cfg_resp_state_e       state;
    logic [CFG_ADDR_W-1:0] addr_q;
    logic [CFG_DATA_W-1:0] wdata_q;
    logic [CFG_BE_W-1:0]   be_q;
    logic                  wr_q;

    logic [4:0]            ch_q;
    logic [1:0]            sel_q;
    logic                  mapped;
    logic                  commit;
    logic                  err_inc;
    logic [CFG_DATA_W-1:0] rd_mux;
    logic [CFG_DATA_W-1:0] ch_rdata [NUM_CH];

    assign ch_q   = addr_q[15:11];
    assign sel_q  = cfg_ofs_sel(addr_q[10:0]);
    assign mapped = !addr_q[16] && ({1'b0, ch_q} < NUM_CH_L) && (sel_q != CFG_SEL_NONE);
    assign commit = (state == ACK) && wr_q && mapped;

    assign avs_waitrequest   = (state != ACK);
    assign avs_readdatavalid = (state == RD_DATA);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            wr_q         <= 1'b0;
            avs_readdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (avs_write || avs_read) begin
                        addr_q  <= avs_address;
                        wdata_q <= avs_writedata;
                        be_q    <= avs_byteenable;
                        wr_q    <= avs_write;
                        state   <= ACK;
                    end
                end
                ACK: begin
                    if (wr_q) begin
                        state <= IDLE;
                    end else begin
                        avs_readdata <= rd_mux;
                        state        <= RD_DATA;
                    end
                end
                RD_DATA: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Collisions count at the IDLE sample, unmapped accesses at the ACK edge
    assign err_inc = ((state == IDLE) && avs_write && avs_read) || ((state == ACK) && !mapped);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_cnt <= '0;
        else if (err_inc && err_cnt != 8'hFF)
            err_cnt <= err_cnt + 8'd1;
    end

    always_comb begin
        rd_mux = UNMAPPED_RDATA;
        if (mapped) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (ch_q == 5'(c))
                    rd_mux = ch_rdata[c];
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        avmm_cfg_ch_regs u_regs (
            .clk     (clk),
            .rst     (rst),
            .clear   (cfg_clear),
            .wr_en   (commit && (ch_q == 5'(c))),
            .wr_sel  (sel_q),
            .wr_data (wdata_q),
            .wr_be   (be_q),
            .rd_sel  (sel_q),
            .rd_data (ch_rdata[c]),
            .done    (cfg_done[c])
        );
    end

endmodule

// File: tb/tb_avmm_cfg_responder.sv
// Self-checking bench for avmm_cfg_responder against a behavioural
// register-file model with written flags and a saturating error count.
module tb_avmm_cfg_responder;

    localparam int          NUM_CH = 24;
    localparam logic [31:0] UNM    = 32'hDEAD_BEEF;

    logic              clk;
    logic              rst;
    logic [16:0]       avs_address;
    logic              avs_write;
    logic              avs_read;
    logic [31:0]       avs_writedata;
    logic [3:0]        avs_byteenable;
    logic              avs_waitrequest;
    logic [31:0]       avs_readdata;
    logic              avs_readdatavalid;
    logic              cfg_clear;
    logic [NUM_CH-1:0] cfg_done;
    logic [7:0]        err_cnt;

    int tests = 0;
    int fails = 0;
    int rdv_cnt = 0;
    int lat_errs = 0;

    logic [31:0] m_mem  [32][3];
    bit          m_flag [32][3];
    int          m_err;

    avmm_cfg_responder #(.NUM_CH(NUM_CH), .UNMAPPED_RDATA(UNM)) dut (
        .clk               (clk),
        .rst               (rst),
        .avs_address       (avs_address),
        .avs_write         (avs_write),
        .avs_read          (avs_read),
        .avs_writedata     (avs_writedata),
        .avs_byteenable    (avs_byteenable),
        .avs_waitrequest   (avs_waitrequest),
        .avs_readdata      (avs_readdata),
        .avs_readdatavalid (avs_readdatavalid),
        .cfg_clear         (cfg_clear),
        .cfg_done          (cfg_done),
        .err_cnt           (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (avs_readdatavalid === 1'b1) rdv_cnt <= rdv_cnt + 1;

    // ---------------- reference model ----------------
    function automatic int ofs_idx(input logic [10:0] o);
        if (o == 11'h208) return 0;
        if (o == 11'h210) return 1;
        if (o == 11'h218) return 2;
        return -1;
    endfunction

    function automatic bit is_mapped(input logic [16:0] a);
        return (a[16] == 1'b0) && (int'(a[15:11]) < NUM_CH) && (ofs_idx(a[10:0]) >= 0);
    endfunction

    function automatic logic [16:0] mk(input bit msb, input int ch, input logic [10:0] o);
        return {msb, 5'(ch), o};
    endfunction

    function automatic logic [NUM_CH-1:0] m_done_vec();
        logic [NUM_CH-1:0] v;
        for (int c = 0; c < NUM_CH; c++) v[c] = m_flag[c][0] && m_flag[c][1] && m_flag[c][2];
        return v;
    endfunction

    task automatic model_clear();
        for (int c = 0; c < 32; c++) for (int r = 0; r < 3; r++) m_flag[c][r] = 0;
    endtask

    task automatic model_reset();
        for (int c = 0; c < 32; c++) for (int r = 0; r < 3; r++) m_mem[c][r] = '0;
        model_clear();
        m_err = 0;
    endtask

    task automatic model_err_inc();
        if (m_err < 255) m_err++;
    endtask

    task automatic model_write(input logic [16:0] a, input logic [31:0] d, input logic [3:0] be);
        int ch, r;
        if (is_mapped(a)) begin
            ch = int'(a[15:11]);
            r  = ofs_idx(a[10:0]);
            for (int b = 0; b < 4; b++) if (be[b]) m_mem[ch][r][8*b +: 8] = d[8*b +: 8];
            m_flag[ch][r] = 1;
        end else begin
            model_err_inc();
        end
    endtask

    task automatic model_read(input logic [16:0] a, output logic [31:0] exp);
        if (is_mapped(a)) begin
            exp = m_mem[int'(a[15:11])][ofs_idx(a[10:0])];
        end else begin
            exp = UNM;
            model_err_inc();
        end
    endtask

    // ---------------- bus driver ----------------
    task automatic bus_op(input bit wr, input bit rd, input logic [16:0] a, input logic [31:0] d,
                          input logic [3:0] be, input bit clr,
                          output logic [31:0] rdata, output logic rdv);
        int lat;
        avs_write = wr; avs_read = rd; avs_address = a; avs_writedata = d; avs_byteenable = be;
        lat = 0;
        do begin
            @(posedge clk); #1; lat++;
        end while (avs_waitrequest !== 1'b0 && lat < 8);
        if (lat != 1) lat_errs++;
        if (clr) cfg_clear = 1'b1;
        @(posedge clk); #1;
        cfg_clear = 1'b0; avs_write = 1'b0; avs_read = 1'b0;
        rdata = avs_readdata;
        rdv   = avs_readdatavalid;
        if (rd && !wr) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_write(input logic [16:0] a, input logic [31:0] d, input logic [3:0] be, input bit clr);
        logic [31:0] rdd;
        logic        v;
        bus_op(1'b1, 1'b0, a, d, be, clr, rdd, v);
        if (clr) model_clear();
        model_write(a, d, be);
    endtask

    task automatic do_read(input logic [16:0] a, output logic [31:0] rdata, output logic rdv,
                           output logic [31:0] exp);
        bus_op(1'b0, 1'b1, a, 32'h0, 4'h0, 1'b0, rdata, rdv);
        model_read(a, exp);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] rd, exp;
        logic        v;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
        tests++; if (avs_waitrequest !== 1'b1) begin fails++; $display("FAIL reset_waitreq: got %b expected 1", avs_waitrequest); end
        tests++; if (avs_readdatavalid !== 1'b0) begin fails++; $display("FAIL reset_rdv: got %b expected 0", avs_readdatavalid); end
        tests++; if (avs_readdata !== 32'h0) begin fails++; $display("FAIL reset_rdata: got %h expected 0", avs_readdata); end
        tests++; if (cfg_done !== '0) begin fails++; $display("FAIL reset_done: got %h expected 0", cfg_done); end
        tests++; if (err_cnt !== 8'h0) begin fails++; $display("FAIL reset_err: got %0d expected 0", err_cnt); end
        do_read(mk(0, 3, 11'h208), rd, v, exp);
        tests++; if (v !== 1'b1 || rd !== 32'h0) begin fails++; $display("FAIL reset_read_ch3: got rdv=%b data=%h expected rdv=1 data=00000000", v, rd); end
        tests++; if (lat_errs !== 0) begin fails++; $display("FAIL reset_latency: got %0d late handshakes expected 0", lat_errs); end
    endtask

    task automatic test_ch5_done();
        logic [31:0] rd, exp;
        logic        v;
        logic [31:0] vals [3] = '{32'h0600_0000, 32'h0000_000B, 32'h60A1_0000};
        logic [10:0] ofs  [3] = '{11'h208, 11'h210, 11'h218};
        for (int i = 0; i < 3; i++) begin
            do_write(mk(0, 5, ofs[i]), vals[i], 4'hF, 1'b0);
            tests++; if (cfg_done[5] !== 1'b0) begin fails++; $display("FAIL ch5_done_early%0d: got %b expected 0", i, cfg_done[5]); end
        end
        @(posedge clk); #1;
        tests++; if (cfg_done !== m_done_vec() || cfg_done[5] !== 1'b1) begin fails++; $display("FAIL ch5_done: got %h expected %h", cfg_done, m_done_vec()); end
        for (int i = 0; i < 3; i++) begin
            do_read(mk(0, 5, ofs[i]), rd, v, exp);
            tests++; if (v !== 1'b1 || rd !== vals[i]) begin fails++; $display("FAIL ch5_readback%0d: got rdv=%b data=%h expected rdv=1 data=%h", i, v, rd, vals[i]); end
        end
    endtask

    task automatic test_byteenable();
        logic [31:0] rd, exp;
        logic        v;
        do_write(mk(0, 2, 11'h210), 32'hAABB_CCDD, 4'hF, 1'b0);
        do_write(mk(0, 2, 11'h210), 32'h1122_3344, 4'b0101, 1'b0);
        do_read(mk(0, 2, 11'h210), rd, v, exp);
        tests++; if (rd !== 32'hAA22_CC44) begin fails++; $display("FAIL byteenable: got %h expected aa22cc44", rd); end
        do_write(mk(0, 2, 11'h208), 32'hFFFF_FFFF, 4'h0, 1'b0);
        do_read(mk(0, 2, 11'h208), rd, v, exp);
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL byteenable_zero: got %h expected 00000000", rd); end
    endtask

    task automatic test_unmapped();
        logic [31:0] rd, exp;
        logic        v;
        do_write(mk(0, NUM_CH, 11'h208), 32'h1234_5678, 4'hF, 1'b0);
        do_write(mk(0, 5, 11'h20C), 32'h5555_AAAA, 4'hF, 1'b0);
        do_read(mk(1, 5, 11'h208), rd, v, exp);
        tests++; if (v !== 1'b1 || rd !== UNM) begin fails++; $display("FAIL unmapped_rdata: got rdv=%b data=%h expected rdv=1 data=%h", v, rd, UNM); end
        tests++; if (err_cnt !== 8'd3) begin fails++; $display("FAIL unmapped_err: got %0d expected 3", err_cnt); end
        do_read(mk(0, 5, 11'h208), rd, v, exp);
        tests++; if (rd !== 32'h0600_0000) begin fails++; $display("FAIL unmapped_store208: got %h expected 06000000", rd); end
        do_read(mk(0, 5, 11'h210), rd, v, exp);
        tests++; if (rd !== 32'h0000_000B) begin fails++; $display("FAIL unmapped_store210: got %h expected 0000000b", rd); end
        do_read(mk(0, 0, 11'h208), rd, v, exp);
        tests++; if (rd !== exp || err_cnt !== 8'd3) begin fails++; $display("FAIL unmapped_ch0: got data=%h err=%0d expected data=%h err=3", rd, err_cnt, exp); end
    endtask

    task automatic test_clear_commit();
        tests++; if (cfg_done[5] !== 1'b1) begin fails++; $display("FAIL clear_pre_done: got %b expected 1", cfg_done[5]); end
        do_write(mk(0, 5, 11'h218), 32'h0000_0218, 4'hF, 1'b1);
        @(posedge clk); #1;
        tests++; if (cfg_done !== m_done_vec() || cfg_done[5] !== 1'b0) begin fails++; $display("FAIL clear_commit: got %h expected %h", cfg_done, m_done_vec()); end
        do_write(mk(0, 5, 11'h208), 32'h0000_0208, 4'hF, 1'b0);
        do_write(mk(0, 5, 11'h210), 32'h0000_0210, 4'hF, 1'b0);
        do_write(mk(0, 2, 11'h208), 32'h2222_0208, 4'hF, 1'b0);
        do_write(mk(0, 2, 11'h218), 32'h2222_0218, 4'hF, 1'b0);
        @(posedge clk); #1;
        tests++; if (cfg_done !== m_done_vec() || cfg_done[5] !== 1'b1 || cfg_done[2] !== 1'b0) begin fails++; $display("FAIL clear_rewrite: got %h expected %h", cfg_done, m_done_vec()); end
    endtask

    task automatic test_collision();
        logic [31:0] rd, exp;
        logic        v;
        int          rdv0;
        rdv0 = rdv_cnt;
        bus_op(1'b1, 1'b1, mk(0, 7, 11'h210), 32'hC011_1DE5, 4'hF, 1'b0, rd, v);
        model_err_inc();
        model_write(mk(0, 7, 11'h210), 32'hC011_1DE5, 4'hF);
        repeat (2) @(posedge clk);
        #1;
        tests++; if (rdv_cnt !== rdv0) begin fails++; $display("FAIL collision_rdv: got %0d pulses expected 0", rdv_cnt - rdv0); end
        tests++; if (err_cnt !== 8'(m_err)) begin fails++; $display("FAIL collision_err: got %0d expected %0d", err_cnt, m_err); end
        do_read(mk(0, 7, 11'h210), rd, v, exp);
        tests++; if (rd !== 32'hC011_1DE5) begin fails++; $display("FAIL collision_write: got %h expected c0111de5", rd); end
    endtask

    task automatic test_random();
        logic [31:0] rd, exp, d;
        logic [16:0] a;
        logic [10:0] o;
        logic        v;
        int          r, ch, k, op, bad;
        bad = 0;
        for (int n = 0; n < 200; n++) begin
            r  = $urandom_range(0, 99);
            ch = (r < 12) ? $urandom_range(NUM_CH, 31) : $urandom_range(0, NUM_CH - 1);
            k  = $urandom_range(0, 9);
            o  = (k < 3) ? 11'h208 : (k < 6) ? 11'h210 : (k < 9) ? 11'h218 : 11'($urandom);
            a  = mk(r < 5, ch, o);
            d  = $urandom;
            op = $urandom_range(0, 9);
            if (op < 5) begin
                do_write(a, d, 4'($urandom), 1'b0);
            end else if (op < 9) begin
                do_read(a, rd, v, exp);
                if (v !== 1'b1 || rd !== exp) begin
                    bad++;
                    if (bad < 5) $display("FAIL random_read addr=%h: got rdv=%b data=%h expected rdv=1 data=%h", a, v, rd, exp);
                end
            end else begin
                cfg_clear = 1'b1;
                @(posedge clk); #1;
                cfg_clear = 1'b0;
                model_clear();
            end
        end
        tests++; if (bad !== 0) begin fails++; $display("FAIL random_reads: got %0d bad reads expected 0", bad); end
        @(posedge clk); #1;
        tests++; if (cfg_done !== m_done_vec()) begin fails++; $display("FAIL random_done: got %h expected %h", cfg_done, m_done_vec()); end
        tests++; if (err_cnt !== 8'(m_err)) begin fails++; $display("FAIL random_err: got %0d expected %0d", err_cnt, m_err); end
        tests++; if (lat_errs !== 0) begin fails++; $display("FAIL random_latency: got %0d late handshakes expected 0", lat_errs); end
    endtask

    task automatic test_saturation();
        for (int n = 0; n < 300; n++) do_write(mk(1, 0, 11'h208), 32'h0, 4'hF, 1'b0);
        tests++; if (err_cnt !== 8'hFF || m_err !== 255) begin fails++; $display("FAIL err_saturate: got %0d expected 255", err_cnt); end
    endtask

    task automatic test_reset_mid_read();
        logic [31:0] rd, exp;
        logic        v;
        int          rdv0, t;
        avs_read = 1'b1; avs_address = mk(0, 5, 11'h208);
        t = 0;
        do begin
            @(posedge clk); #1; t++;
        end while (avs_waitrequest !== 1'b0 && t < 8);
        tests++; if (t !== 1) begin fails++; $display("FAIL abort_reach_ack: got %0d cycles expected 1", t); end
        rdv0 = rdv_cnt;
        rst = 1'b1;
        #1;
        avs_read = 1'b0;
        model_reset();
        tests++; if (avs_waitrequest !== 1'b1 || avs_readdatavalid !== 1'b0 || avs_readdata !== 32'h0 || cfg_done !== '0 || err_cnt !== 8'h0) begin
            fails++; $display("FAIL abort_outputs: got wr=%b rdv=%b data=%h done=%h err=%0d expected 1 0 0 0 0",
                              avs_waitrequest, avs_readdatavalid, avs_readdata, cfg_done, err_cnt);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (rdv_cnt !== rdv0) begin fails++; $display("FAIL abort_rdv: got %0d pulses expected 0", rdv_cnt - rdv0); end
        do_read(mk(0, 5, 11'h208), rd, v, exp);
        tests++; if (rd !== 32'h0 || rd !== exp) begin fails++; $display("FAIL abort_regs_cleared: got %h expected 00000000", rd); end
    endtask

    initial begin
        rst = 1'b1; avs_address = '0; avs_write = 1'b0; avs_read = 1'b0;
        avs_writedata = '0; avs_byteenable = '0; cfg_clear = 1'b0;
        model_reset();
        test_reset();
        test_ch5_done();
        test_byteenable();
        test_unmapped();
        test_clear_commit();
        test_collision();
        test_random();
        test_saturation();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
